// File: rtl/vie_dreq_unit_pkg.sv
// Shared definitions for the vie data-request unit: op codes, access sizes,
// FSM state encoding, the registered request record and op classification.
package vie_dreq_unit_pkg;

    localparam int VIE_OP_W = 8;

    // Load/store op codes (values follow the MIPS primary opcodes)
    localparam logic [VIE_OP_W-1:0] VIE_OP_LB  = 8'h20;
    localparam logic [VIE_OP_W-1:0] VIE_OP_LH  = 8'h21;
    localparam logic [VIE_OP_W-1:0] VIE_OP_LWL = 8'h22;
    localparam logic [VIE_OP_W-1:0] VIE_OP_LW  = 8'h23;
    localparam logic [VIE_OP_W-1:0] VIE_OP_LBU = 8'h24;
    localparam logic [VIE_OP_W-1:0] VIE_OP_LHU = 8'h25;
    localparam logic [VIE_OP_W-1:0] VIE_OP_LWR = 8'h26;
    localparam logic [VIE_OP_W-1:0] VIE_OP_SB  = 8'h28;
    localparam logic [VIE_OP_W-1:0] VIE_OP_SH  = 8'h29;
    localparam logic [VIE_OP_W-1:0] VIE_OP_SWL = 8'h2A;
    localparam logic [VIE_OP_W-1:0] VIE_OP_SW  = 8'h2B;
    localparam logic [VIE_OP_W-1:0] VIE_OP_SWR = 8'h2E;

    // SRAM-like access size encodings
    localparam logic [1:0] VIE_SIZE_B = 2'd0;
    localparam logic [1:0] VIE_SIZE_H = 2'd1;
    localparam logic [1:0] VIE_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        CANCEL = 2'd3
    } dreq_state_e;

    // Request captured on issue and held stable while the request is live
    typedef struct packed {
        logic        wr;
        logic        load;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dreq_req_t;

    function automatic logic vie_is_load(input logic [VIE_OP_W-1:0] op);
        case (op)
            VIE_OP_LB, VIE_OP_LBU, VIE_OP_LH, VIE_OP_LHU,
            VIE_OP_LW, VIE_OP_LWL, VIE_OP_LWR: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic vie_is_store(input logic [VIE_OP_W-1:0] op);
        case (op)
            VIE_OP_SB, VIE_OP_SH, VIE_OP_SW,
            VIE_OP_SWL, VIE_OP_SWR: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Natural-alignment fault; the unaligned word ops never fault
    function automatic logic vie_addr_err(input logic [VIE_OP_W-1:0] op,
                                          input logic [1:0]          lo);
        case (op)
            VIE_OP_LH, VIE_OP_LHU, VIE_OP_SH: return lo[0];
            VIE_OP_LW, VIE_OP_SW:             return |lo;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vie_dreq_unit_if.sv
// SRAM-like data bus between the request initiator (master) and memory (slave).
interface vie_dreq_unit_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/vie_store_align.sv
// Combinational access shaping: size, byte strobes, lane-aligned write data
// and whether the address must be forced to a word boundary.
module vie_store_align
    import vie_dreq_unit_pkg::*;
(
    input  logic [VIE_OP_W-1:0] op_i,
    input  logic [1:0]          sel_i,
    input  logic [31:0]         rt_i,
    output logic [1:0]          size_o,
    output logic [3:0]          wstrb_o,
    output logic [31:0]         wdata_o,
    output logic                word_aligned_o
);

    // Decode the op into its bus shape; loads carry no strobes or data
    always_comb begin
        size_o         = VIE_SIZE_W;
        wstrb_o        = 4'b0000;
        wdata_o        = 32'h0;
        word_aligned_o = 1'b0;
        case (op_i)
            VIE_OP_LB, VIE_OP_LBU: size_o = VIE_SIZE_B;
            VIE_OP_LH, VIE_OP_LHU: size_o = VIE_SIZE_H;
            VIE_OP_LW:             size_o = VIE_SIZE_W;
            VIE_OP_LWL, VIE_OP_LWR: begin
                size_o         = VIE_SIZE_W;
                word_aligned_o = 1'b1;
            end
            VIE_OP_SB: begin
                size_o  = VIE_SIZE_B;
                wstrb_o = 4'b0001 << sel_i;
                wdata_o = {4{rt_i[7:0]}};
            end
            VIE_OP_SH: begin
                size_o  = VIE_SIZE_H;
                wstrb_o = 4'b0011 << sel_i;
                wdata_o = {2{rt_i[15:0]}};
            end
            VIE_OP_SW: begin
                size_o  = VIE_SIZE_W;
                wstrb_o = 4'b1111;
                wdata_o = rt_i;
            end
            VIE_OP_SWL: begin
                // Most significant bytes of rt land in lanes sel..0
                size_o         = VIE_SIZE_W;
                word_aligned_o = 1'b1;
                case (sel_i)
                    2'd0:    begin wstrb_o = 4'b0001; wdata_o = {24'h0, rt_i[31:24]}; end
                    2'd1:    begin wstrb_o = 4'b0011; wdata_o = {16'h0, rt_i[31:16]}; end
                    2'd2:    begin wstrb_o = 4'b0111; wdata_o = {8'h0,  rt_i[31:8]};  end
                    default: begin wstrb_o = 4'b1111; wdata_o = rt_i;                 end
                endcase
            end
            VIE_OP_SWR: begin
                // Least significant bytes of rt land in lanes sel..3
                size_o         = VIE_SIZE_W;
                word_aligned_o = 1'b1;
                case (sel_i)
                    2'd0:    begin wstrb_o = 4'b1111; wdata_o = rt_i;                 end
                    2'd1:    begin wstrb_o = 4'b1110; wdata_o = {rt_i[23:0], 8'h0};  end
                    2'd2:    begin wstrb_o = 4'b1100; wdata_o = {rt_i[15:0], 16'h0}; end
                    default: begin wstrb_o = 4'b1000; wdata_o = {rt_i[7:0], 24'h0};  end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vie_dreq_unit.sv
// Data-side request initiator: issues one SRAM-like transaction at a time for
// execute-stage loads/stores, reports address errors, survives flushes, and
// buffers returned load words until the memory stage acknowledges them.
module vie_dreq_unit
    import vie_dreq_unit_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                es_valid,
    input  logic [VIE_OP_W-1:0] es_op,
    input  logic [31:0]         es_addr,
    input  logic [31:0]         es_rt,
    input  logic                es_cancel,
    input  logic                flush,
    output logic                es_go,
    output logic                adel,
    output logic                ades,
    vie_dreq_unit_if.master     dbus,
    output logic                rd_valid,
    output logic [31:0]         rd_data,
    input  logic                rd_ack
);

    dreq_state_e state_q, state_d;
    dreq_req_t   req_q, req_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic        is_load, is_store, mem_op, addr_err;
    logic        issue, req_go, bypass;
    logic [1:0]  al_size;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic        al_word;

    assign is_load  = vie_is_load(es_op);
    assign is_store = vie_is_store(es_op);
    assign mem_op   = is_load | is_store;
    assign addr_err = vie_addr_err(es_op, es_addr[1:0]);

    // A new request may only start from IDLE, and never over an unconsumed load word
    assign issue = (state_q == IDLE) & es_valid & mem_op & ~es_cancel & ~addr_err
                 & ~flush & ~rd_valid_q;

    vie_store_align u_align (
        .op_i           (es_op),
        .sel_i          (es_addr[1:0]),
        .rt_i           (es_rt),
        .size_o         (al_size),
        .wstrb_o        (al_wstrb),
        .wdata_o        (al_wdata),
        .word_aligned_o (al_word)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and the request-side handshake grant
    always_comb begin
        state_d = state_q;
        req_go  = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) state_d = REQ;
            end
            REQ: begin
                if (dbus.data_addr_ok) begin
                    if (flush) begin
                        state_d = CANCEL;
                    end else begin
                        state_d = WAIT;
                        req_go  = 1'b1;
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (dbus.data_data_ok) state_d = IDLE;
                else if (flush)        state_d = CANCEL;
            end
            CANCEL: begin
                // Flushes here are irrelevant; only the orphaned response matters
                if (dbus.data_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ops that need no bus access (non-memory, cancelled, misaligned) pass straight through
    always_comb begin
        bypass = ~reset & es_valid & (state_q != CANCEL)
               & (~mem_op | es_cancel | addr_err);
        es_go  = bypass | req_go;
        adel   = bypass & mem_op & ~es_cancel & addr_err & is_load;
        ades   = bypass & mem_op & ~es_cancel & addr_err & is_store;
    end

    // Capture the shaped request on issue; hold it unchanged otherwise
    always_comb begin
        req_d = req_q;
        if (issue) begin
            req_d.wr    = is_store;
            req_d.load  = is_load;
            req_d.size  = al_size;
            req_d.addr  = al_word ? {es_addr[31:2], 2'b00} : es_addr;
            req_d.wstrb = al_wstrb;
            req_d.wdata = al_wdata;
        end
    end

    // Request field registers
    always_ff @(posedge clock) begin
        if (reset) req_q <= '0;
        else       req_q <= req_d;
    end

    // Load-data buffer: fill on a live load response, drain on ack, flush wins
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (rd_ack) rd_valid_d = 1'b0;
        if ((state_q == WAIT) & dbus.data_data_ok & ~flush & req_q.load) begin
            rd_valid_d = 1'b1;
            rd_data_d  = dbus.data_rdata;
        end
        if (flush) rd_valid_d = 1'b0;
    end

    // Load-data buffer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'h0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign dbus.data_req   = (state_q == REQ);
    assign dbus.data_wr    = req_q.wr;
    assign dbus.data_size  = req_q.size;
    assign dbus.data_addr  = req_q.addr;
    assign dbus.data_wstrb = req_q.wstrb;
    assign dbus.data_wdata = req_q.wdata;
    assign rd_valid        = rd_valid_q;
    assign rd_data         = rd_data_q;

endmodule

// File: tb/tb_vie_dreq_unit.sv
// Bench for vie_dreq_unit: directed scenarios plus randomized ops checked
// against a byte-lane reference model.
module tb_vie_dreq_unit;
    import vie_dreq_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        es_valid;
    logic [7:0]  es_op;
    logic [31:0] es_addr;
    logic [31:0] es_rt;
    logic        es_cancel;
    logic        flush;
    logic        es_go, adel, ades;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ack;

    int n_assert = 0;
    int n_fail   = 0;

    vie_dreq_unit_if dbus ();

    vie_dreq_unit dut (
        .clock     (clock),
        .reset     (reset),
        .es_valid  (es_valid),
        .es_op     (es_op),
        .es_addr   (es_addr),
        .es_rt     (es_rt),
        .es_cancel (es_cancel),
        .flush     (flush),
        .es_go     (es_go),
        .adel      (adel),
        .ades      (ades),
        .dbus      (dbus),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ack    (rd_ack)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reference model: derive the bus request from byte-lane rules
    function automatic void model(input logic [7:0] op, input logic [31:0] a,
                                  input logic [31:0] rt,
                                  output logic mem, output logic ld, output logic err,
                                  output logic [1:0] sz, output logic [31:0] addr,
                                  output logic [3:0] strb, output logic [31:0] wd);
        int nbytes, sel, b;
        logic en, partial;
        ld  = op inside {VIE_OP_LB, VIE_OP_LBU, VIE_OP_LH, VIE_OP_LHU,
                         VIE_OP_LW, VIE_OP_LWL, VIE_OP_LWR};
        mem = ld || (op inside {VIE_OP_SB, VIE_OP_SH, VIE_OP_SW, VIE_OP_SWL, VIE_OP_SWR});
        partial = op inside {VIE_OP_LWL, VIE_OP_LWR, VIE_OP_SWL, VIE_OP_SWR};
        if (op inside {VIE_OP_LH, VIE_OP_LHU, VIE_OP_SH})  nbytes = 2;
        else if (op inside {VIE_OP_LW, VIE_OP_SW} || partial) nbytes = 4;
        else nbytes = 1;
        err  = !partial && ((a % nbytes) != 0);
        sz   = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
        addr = partial ? (a & 32'hFFFF_FFFC) : a;
        sel  = int'(a[1:0]);
        strb = 4'b0;
        wd   = 32'h0;
        for (int k = 0; k < 4; k++) begin
            en = 1'b0;
            b  = -1;
            case (op)
                VIE_OP_SB:  begin en = (k == sel);                 b = 0;           end
                VIE_OP_SH:  begin en = (k >= sel) && (k < sel + 2); b = k % 2;      end
                VIE_OP_SW:  begin en = 1'b1;                       b = k;           end
                VIE_OP_SWL: begin en = (k <= sel);   b = en ? (3 - sel + k) : -1;   end
                VIE_OP_SWR: begin en = (k >= sel);   b = en ? (k - sel) : -1;       end
                default: ;
            endcase
            strb[k] = en;
            if (b >= 0) wd[8*k +: 8] = rt[8*b +: 8];
        end
    endfunction

    // One op through the execute stage, with the bench acting as the memory
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rt,
                          input logic cancel, input int a_wait, input int d_wait,
                          input logic [31:0] rdata, output logic pend);
        logic mem, ld, err;
        logic [1:0] sz;
        logic [31:0] ad, wd;
        logic [3:0] st;
        model(op, a, rt, mem, ld, err, sz, ad, st, wd);
        pend      = mem && ld && !err && !cancel;
        es_valid  = 1'b1;
        es_op     = op;
        es_addr   = a;
        es_rt     = rt;
        es_cancel = cancel;
        @(negedge clock);
        if (!mem || cancel || err) begin
            chk("go_bypass", es_go, 1'b1);
            chk("adel", adel, mem && ld && err && !cancel);
            chk("ades", ades, mem && !ld && err && !cancel);
            chk("req_bypass", dbus.data_req, 1'b0);
            tick;
            es_valid  = 1'b0;
            es_cancel = 1'b0;
            @(negedge clock);
            chk("req_after_bypass", dbus.data_req, 1'b0);
            tick;
            return;
        end
        chk("go_issue", es_go, 1'b0);
        chk("req_issue", dbus.data_req, 1'b0);
        tick;
        for (int i = 0; i <= a_wait; i++) begin
            dbus.data_addr_ok = (i == a_wait);
            @(negedge clock);
            chk("req_live", dbus.data_req, 1'b1);
            chk("go_req", es_go, (i == a_wait));
            chk("wr", dbus.data_wr, !ld);
            chk("size", dbus.data_size, sz);
            chk("addr", dbus.data_addr, ad);
            chk("wstrb", dbus.data_wstrb, st);
            if (!ld) chk("wdata", dbus.data_wdata, wd);
            tick;
        end
        dbus.data_addr_ok = 1'b0;
        es_valid = 1'b0;
        for (int i = 0; i <= d_wait; i++) begin
            dbus.data_data_ok = (i == d_wait);
            dbus.data_rdata   = (i == d_wait) ? rdata : $urandom;
            @(negedge clock);
            chk("req_wait", dbus.data_req, 1'b0);
            tick;
        end
        dbus.data_data_ok = 1'b0;
        @(negedge clock);
        chk("rd_valid_done", rd_valid, pend);
        if (pend) chk("rd_data_done", rd_data, rdata);
        chk("req_idle", dbus.data_req, 1'b0);
        tick;
    endtask

    task automatic ack_rd(input int delay, input logic [31:0] exp_data);
        for (int i = 0; i < delay; i++) begin
            @(negedge clock);
            chk("rd_hold_valid", rd_valid, 1'b1);
            chk("rd_hold_data", rd_data, exp_data);
            tick;
        end
        rd_ack = 1'b1;
        tick;
        rd_ack = 1'b0;
        @(negedge clock);
        chk("rd_acked", rd_valid, 1'b0);
        tick;
    endtask

    logic [7:0] ops [14] = '{VIE_OP_LB, VIE_OP_LBU, VIE_OP_LH, VIE_OP_LHU, VIE_OP_LW,
                             VIE_OP_LWL, VIE_OP_LWR, VIE_OP_SB, VIE_OP_SH, VIE_OP_SW,
                             VIE_OP_SWL, VIE_OP_SWR, 8'h00, 8'h0F};

    initial begin
        logic pend;
        logic [31:0] rdat;
        reset = 1'b1; es_valid = 1'b0; es_op = 8'h00; es_addr = 32'h0; es_rt = 32'h0;
        es_cancel = 1'b0; flush = 1'b0; rd_ack = 1'b0;
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0; dbus.data_rdata = 32'h0;
        repeat (3) tick;
        @(negedge clock);
        chk("rst_es_go", es_go, 1'b0);
        chk("rst_adel", adel, 1'b0);
        chk("rst_ades", ades, 1'b0);
        chk("rst_req", dbus.data_req, 1'b0);
        chk("rst_wr", dbus.data_wr, 1'b0);
        chk("rst_size", dbus.data_size, 2'd0);
        chk("rst_addr", dbus.data_addr, 32'h0);
        chk("rst_wstrb", dbus.data_wstrb, 4'h0);
        chk("rst_wdata", dbus.data_wdata, 32'h0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        tick;
        reset = 1'b0;
        tick;

        // SW with two request cycles, response one cycle after acceptance
        run_op(VIE_OP_SW, 32'h100, 32'hAABBCCDD, 1'b0, 1, 0, 32'h0, pend);
        chk("sw_wstrb_const", dbus.data_wstrb, 4'b1111);
        chk("sw_wdata_const", dbus.data_wdata, 32'hAABBCCDD);

        // SWL / SWR lane placement
        run_op(VIE_OP_SWL, 32'h101, 32'h11223344, 1'b0, 0, 1, 32'h0, pend);
        chk("swl_addr_const", dbus.data_addr, 32'h100);
        chk("swl_wstrb_const", dbus.data_wstrb, 4'b0011);
        chk("swl_wdata_const", dbus.data_wdata, 32'h00001122);
        run_op(VIE_OP_SWR, 32'h102, 32'h11223344, 1'b0, 0, 0, 32'h0, pend);
        chk("swr_wstrb_const", dbus.data_wstrb, 4'b1100);
        chk("swr_wdata_const", dbus.data_wdata, 32'h33440000);

        // LW buffered, following LB stalled until ack
        run_op(VIE_OP_LW, 32'h10, 32'h0, 1'b0, 0, 0, 32'hDEADBEEF, pend);
        es_valid = 1'b1; es_op = VIE_OP_LB; es_addr = 32'h21;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_rd_valid", rd_valid, 1'b1);
            chk("stall_rd_data", rd_data, 32'hDEADBEEF);
            chk("stall_req", dbus.data_req, 1'b0);
            chk("stall_go", es_go, 1'b0);
            tick;
        end
        rd_ack = 1'b1;
        @(negedge clock);
        chk("ack_cycle_req", dbus.data_req, 1'b0);
        tick;
        rd_ack = 1'b0;
        run_op(VIE_OP_LB, 32'h21, 32'h0, 1'b0, 0, 0, 32'h000000A5, pend);
        ack_rd(0, 32'h000000A5);

        // Misaligned LH, plain and cancelled
        run_op(VIE_OP_LH, 32'h203, 32'h0, 1'b0, 0, 0, 32'h0, pend);
        run_op(VIE_OP_LH, 32'h203, 32'h0, 1'b1, 0, 0, 32'h0, pend);
        run_op(VIE_OP_SW, 32'h202, 32'h0, 1'b0, 0, 0, 32'h0, pend);

        // Flush in WAIT: response discarded, extra flush in CANCEL ignored
        es_valid = 1'b1; es_op = VIE_OP_LW; es_addr = 32'h40; es_cancel = 1'b0;
        tick;
        dbus.data_addr_ok = 1'b1;
        @(negedge clock);
        chk("fw_req", dbus.data_req, 1'b1);
        tick;
        dbus.data_addr_ok = 1'b0; es_valid = 1'b0; flush = 1'b1;
        @(negedge clock);
        chk("fw_wait_req", dbus.data_req, 1'b0);
        tick;
        flush = 1'b0; es_valid = 1'b1; es_addr = 32'h44;
        @(negedge clock);
        chk("fw_cancel_go", es_go, 1'b0);
        chk("fw_cancel_req", dbus.data_req, 1'b0);
        tick;
        flush = 1'b1;
        @(negedge clock);
        chk("fw_cancel2_req", dbus.data_req, 1'b0);
        tick;
        flush = 1'b0; dbus.data_data_ok = 1'b1; dbus.data_rdata = 32'h12345678;
        @(negedge clock);
        chk("fw_resp_req", dbus.data_req, 1'b0);
        tick;
        dbus.data_data_ok = 1'b0; es_valid = 1'b0;
        @(negedge clock);
        chk("fw_discard", rd_valid, 1'b0);
        tick;
        run_op(VIE_OP_LW, 32'h48, 32'h0, 1'b0, 1, 1, 32'hCAFEF00D, pend);
        ack_rd(1, 32'hCAFEF00D);

        // Flush in REQ without acceptance: request withdrawn
        es_valid = 1'b1; es_op = VIE_OP_SW; es_addr = 32'h80; es_rt = 32'h55667788;
        tick;
        flush = 1'b1;
        @(negedge clock);
        chk("fr_req_live", dbus.data_req, 1'b1);
        tick;
        flush = 1'b0; es_valid = 1'b0;
        @(negedge clock);
        chk("fr_req_drop", dbus.data_req, 1'b0);
        tick;

        // Flush coincident with acceptance: orphaned response discarded
        es_valid = 1'b1; es_op = VIE_OP_LBU; es_addr = 32'h83;
        tick;
        flush = 1'b1; dbus.data_addr_ok = 1'b1;
        @(negedge clock);
        chk("fa_go", es_go, 1'b0);
        tick;
        flush = 1'b0; dbus.data_addr_ok = 1'b0; es_valid = 1'b0;
        @(negedge clock);
        chk("fa_cancel_req", dbus.data_req, 1'b0);
        tick;
        dbus.data_data_ok = 1'b1; dbus.data_rdata = 32'h0BADF00D;
        tick;
        dbus.data_data_ok = 1'b0;
        @(negedge clock);
        chk("fa_discard", rd_valid, 1'b0);
        tick;

        // Flush beats ack on a buffered word
        run_op(VIE_OP_LWR, 32'h307, 32'h0, 1'b0, 0, 2, 32'h89ABCDEF, pend);
        flush = 1'b1; rd_ack = 1'b1;
        tick;
        flush = 1'b0; rd_ack = 1'b0;
        @(negedge clock);
        chk("flush_rd_clear", rd_valid, 1'b0);
        tick;

        // Randomized ops against the model
        for (int n = 0; n < 60; n++) begin
            rdat = $urandom;
            run_op(ops[$urandom_range(0, 13)], $urandom, $urandom,
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                   $urandom_range(0, 3), rdat, pend);
            if (pend) ack_rd($urandom_range(0, 2), rdat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
